mem_responder: RTL and testbench

- Clocked memory-side responder for the 8-bit accumulator CPU's rd/wr/addr/data bus.
- Replaces the combinational memory model: it owns a 32x8 storage array and answers CPU read/write requests after a programmable number of wait states, signalling completion with cpu_ready.
- A host load port writes program/data bytes into the array while the CPU bus is idle (program loading, test backdoor).

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_array.sv | 35 +++
 rtl/mem_responder.sv | 139 +++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared widths, wait-counter size and FSM state encoding for the memory responder.
package mem_bus_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAITING,
    RESP
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU request/response bus plus host load port of the memory responder.
interface mem_responder_if #(
  parameter int unsigned AW = mem_bus_pkg::AW_DEF,
  parameter int unsigned DW = mem_bus_pkg::DW_DEF
) ();

  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          cpu_err;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ack;
  logic          busy;

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, ld_we, ld_addr, ld_data,
    input  cpu_rdata, cpu_ready, cpu_err, ld_ack, busy
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, ld_we, ld_addr, ld_data,
    output cpu_rdata, cpu_ready, cpu_err, ld_ack, busy
  );

endinterface

// File: rtl/mem_array.sv
// DW x 2**AW storage: one synchronous write port and a registered read port.
module mem_array import mem_bus_pkg::*; #(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Clocked memory responder: answers CPU rd/wr after WAIT wait states, accepts host
// load writes while idle.
module mem_responder import mem_bus_pkg::*; #(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned WAIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wr_q;
  logic          err_q;

  logic          accept;
  logic          host_wr;
  logic          commit;
  logic          op_wr;
  logic          op_err;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata;

  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic ready_q, err_out_q, ack_q, busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Host load has priority in IDLE; a held CPU request is picked up next cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    host_wr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ld_we) begin
          host_wr = 1'b1;
        end else if (bus.cpu_rd || bus.cpu_wr) begin
          accept = 1'b1;
          if (WAIT == 0) begin
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CNT_W'(WAIT - 1);
            state_nxt = WAITING;
          end
        end
      end
      WAITING: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so use live inputs.
  always_comb begin
    op_wr    = accept ? bus.cpu_wr : wr_q;
    op_err   = accept ? (bus.cpu_rd && bus.cpu_wr) : err_q;
    op_addr  = accept ? bus.cpu_addr : addr_q;
    op_wdata = accept ? bus.cpu_wdata : wdata_q;
    commit   = (state_nxt == RESP) && !rst;

    mem_we    = (host_wr && !rst) || (commit && op_wr);
    mem_waddr = host_wr ? bus.ld_addr : op_addr;
    mem_wdata = host_wr ? bus.ld_data : op_wdata;
    mem_re    = commit && !op_wr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.cpu_addr;
      wdata_q <= bus.cpu_wdata;
      wr_q    <= bus.cpu_wr;
      err_q   <= bus.cpu_rd && bus.cpu_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q   <= 1'b0;
      err_out_q <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ready_q   <= (state_nxt == RESP);
      err_out_q <= (state_nxt == RESP) && op_err;
      ack_q     <= host_wr;
      busy_q    <= (state_nxt != IDLE);
    end
  end

  assign bus.cpu_ready = ready_q;
  assign bus.cpu_err   = err_out_q;
  assign bus.ld_ack    = ack_q;
  assign bus.busy      = busy_q;

  mem_array #(
    .AW (AW),
    .DW (DW)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (op_addr),
    .rdata (bus.cpu_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder against an array/latency model.
module tb_mem_responder;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned WA = 2;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  mem_responder_if #(.AW(AW), .DW(DW)) ifa ();
  mem_responder_if #(.AW(AW), .DW(DW)) ifb ();

  mem_responder #(.AW(AW), .DW(DW), .WAIT(WA)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  mem_responder #(.AW(AW), .DW(DW), .WAIT(0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] mdl [32];
  logic [7:0] rd_mdl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until cpu_ready is seen, or -1 after a bounded wait.
  task automatic wait_ready_a(output int n);
    bit seen;
    seen = 1'b0;
    n    = -1;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (ifa.cpu_ready) begin
        seen = 1'b1;
        n    = i;
      end
    end
  endtask

  task automatic ld_a(input logic [4:0] addr, input logic [7:0] data);
    ifa.ld_we   = 1'b1;
    ifa.ld_addr = addr;
    ifa.ld_data = data;
    tick();
    ifa.ld_we = 1'b0;
    mdl[addr] = data;
    check("ld_ack_pulse", 32'(ifa.ld_ack), 1);
    tick();
    check("ld_ack_clear", 32'(ifa.ld_ack), 0);
  endtask

  task automatic txn_a(input bit rd, input bit wr, input logic [4:0] addr, input logic [7:0] wd);
    int n;
    ifa.cpu_rd    = rd;
    ifa.cpu_wr    = wr;
    ifa.cpu_addr  = addr;
    ifa.cpu_wdata = wd;
    tick();
    check("busy_after_accept", 32'(ifa.busy), 1);
    ifa.cpu_addr  = 5'($urandom);
    ifa.cpu_wdata = 8'($urandom);
    wait_ready_a(n);
    if (wr) mdl[addr] = wd;
    else    rd_mdl    = mdl[addr];
    check("latency", n, WA);
    check("rdata", 32'(ifa.cpu_rdata), 32'(rd_mdl));
    check("err", 32'(ifa.cpu_err), 32'(rd & wr));
    ifa.cpu_rd = 1'b0;
    ifa.cpu_wr = 1'b0;
    tick();
    check("ready_pulse", 32'(ifa.cpu_ready), 0);
    check("busy_idle", 32'(ifa.busy), 0);
  endtask

  initial begin
    int n;
    int n2;
    ifa.cpu_rd = 1'b0; ifa.cpu_wr = 1'b0; ifa.cpu_addr = '0; ifa.cpu_wdata = '0;
    ifa.ld_we  = 1'b0; ifa.ld_addr = '0; ifa.ld_data = '0;
    ifb.cpu_rd = 1'b0; ifb.cpu_wr = 1'b0; ifb.cpu_addr = '0; ifb.cpu_wdata = '0;
    ifb.ld_we  = 1'b0; ifb.ld_addr = '0; ifb.ld_data = '0;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    rd_mdl = '0;
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    check("rst_ready", 32'(ifa.cpu_ready), 0);
    check("rst_err", 32'(ifa.cpu_err), 0);
    check("rst_ack", 32'(ifa.ld_ack), 0);
    check("rst_busy", 32'(ifa.busy), 0);
    check("rst_rdata", 32'(ifa.cpu_rdata), 0);
    check("rst_b_rdata", 32'(ifb.cpu_rdata), 0);

    for (int a = 0; a < 32; a++) ld_a(5'(a), 8'($urandom));

    // Host load then CPU read with WAIT=2.
    ld_a(5'h03, 8'h5A);
    txn_a(1'b1, 1'b0, 5'h03, 8'h00);
    check("read_5a", 32'(ifa.cpu_rdata), 'h5A);

    // Zero wait states: write then read back.
    ifb.cpu_wr = 1'b1; ifb.cpu_addr = 5'h1F; ifb.cpu_wdata = 8'hC3;
    tick();
    check("b_wr_ready", 32'(ifb.cpu_ready), 1);
    check("b_wr_rdata_kept", 32'(ifb.cpu_rdata), 0);
    ifb.cpu_wr = 1'b0;
    tick();
    check("b_wr_pulse", 32'(ifb.cpu_ready), 0);
    ifb.cpu_rd = 1'b1; ifb.cpu_addr = 5'h1F;
    tick();
    check("b_rd_ready", 32'(ifb.cpu_ready), 1);
    check("b_rd_data", 32'(ifb.cpu_rdata), 'hC3);
    check("b_rd_err", 32'(ifb.cpu_err), 0);
    ifb.cpu_rd = 1'b0;
    tick();
    check("b_rd_pulse", 32'(ifb.cpu_ready), 0);

    // Host load and CPU read in the same idle cycle.
    ifa.ld_we = 1'b1; ifa.ld_addr = 5'h07; ifa.ld_data = 8'h11;
    ifa.cpu_rd = 1'b1; ifa.cpu_addr = 5'h07;
    tick();
    ifa.ld_we = 1'b0;
    mdl[7] = 8'h11;
    check("same_cycle_ack", 32'(ifa.ld_ack), 1);
    check("same_cycle_not_busy", 32'(ifa.busy), 0);
    wait_ready_a(n);
    check("same_cycle_latency", n, WA + 1);
    check("same_cycle_data", 32'(ifa.cpu_rdata), 'h11);
    rd_mdl = 8'h11;
    ifa.cpu_rd = 1'b0;
    tick();

    // rd and wr together: write wins, error flagged.
    txn_a(1'b1, 1'b1, 5'h0A, 8'h99);
    txn_a(1'b1, 1'b0, 5'h0A, 8'h00);
    check("rw_commit", 32'(ifa.cpu_rdata), 'h99);

    // Reset while a write is waiting.
    ld_a(5'h04, 8'h22);
    ifa.cpu_wr = 1'b1; ifa.cpu_addr = 5'h04; ifa.cpu_wdata = 8'h77;
    tick();
    check("abort_busy", 32'(ifa.busy), 1);
    rst_a = 1'b1;
    ifa.cpu_wr = 1'b0;
    tick();
    rst_a = 1'b0;
    check("abort_ready", 32'(ifa.cpu_ready), 0);
    check("abort_err", 32'(ifa.cpu_err), 0);
    check("abort_busy_clr", 32'(ifa.busy), 0);
    check("abort_rdata", 32'(ifa.cpu_rdata), 0);
    rd_mdl = '0;
    txn_a(1'b1, 1'b0, 5'h04, 8'h00);
    check("abort_old_value", 32'(ifa.cpu_rdata), 'h22);
    txn_a(1'b1, 1'b0, 5'h03, 8'h00);
    check("abort_retained", 32'(ifa.cpu_rdata), 'h5A);

    // Host write while busy is dropped.
    ifa.cpu_rd = 1'b1; ifa.cpu_addr = 5'h05;
    tick();
    ifa.ld_we = 1'b1; ifa.ld_addr = 5'h05; ifa.ld_data = ~mdl[5];
    tick();
    ifa.ld_we = 1'b0;
    check("busy_ld_noack", 32'(ifa.ld_ack), 0);
    wait_ready_a(n);
    check("busy_ld_latency", n, WA - 1);
    check("busy_ld_unchanged", 32'(ifa.cpu_rdata), 32'(mdl[5]));
    rd_mdl = mdl[5];
    ifa.cpu_rd = 1'b0;
    tick();
    check("busy_ld_noack2", 32'(ifa.ld_ack), 0);

    // Held read produces back-to-back completions.
    ifa.cpu_rd = 1'b1; ifa.cpu_addr = 5'h10;
    tick();
    wait_ready_a(n);
    check("held_first", n, WA);
    wait_ready_a(n2);
    check("held_spacing", n2, WA + 2);
    check("held_data", 32'(ifa.cpu_rdata), 32'(mdl[16]));
    rd_mdl = mdl[16];
    ifa.cpu_rd = 1'b0;
    tick();

    // Randomized mix of host loads and CPU accesses.
    for (int k = 0; k < 40; k++) begin
      int unsigned kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0:       ld_a(5'($urandom), 8'($urandom));
        1:       txn_a(1'b1, 1'b0, 5'($urandom), 8'($urandom));
        2:       txn_a(1'b0, 1'b1, 5'($urandom), 8'($urandom));
        default: txn_a(1'b1, 1'b1, 5'($urandom), 8'($urandom));
      endcase
    end

    for (int a = 0; a < 32; a += 7) begin
      txn_a(1'b1, 1'b0, 5'(a), 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
